// File: rtl/dmem_responder_pkg.sv
// Shared types for the MEM-stage data memory responder.
package dmem_pkg;

  localparam int DMEM_WORD_BYTES = 4;

  typedef enum logic [1:0] {IDLE, WAIT, COMMIT, RESP} dmem_state_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } dmem_req_t;

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response handshake bundle between the MEM stage (master) and the responder (slave).
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        busy;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_wstrb, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err, busy
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_wstrb, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err, busy
  );
endinterface

// File: rtl/dmem_responder_array.sv
// DEPTH x 32 word storage: one byte-strobed synchronous write port, one read port.
// The read value is captured into the response register by the top in COMMIT.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_we,
  input  logic [ADDR_W-1:0]          i_addr,
  input  logic [31:0]                i_wdata,
  input  logic [DMEM_WORD_BYTES-1:0] i_wstrb,
  output logic [31:0]                o_rdata
);

  logic [31:0] r_mem [DEPTH];

  // Clear every word on reset; otherwise merge the enabled bytes of the store.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      for (int b = 0; b < DMEM_WORD_BYTES; b++) begin
        if (i_wstrb[b]) begin
          r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
        end
      end
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for the MEM-stage data port: one outstanding request,
// serviced after a fixed LATENCY, answered over a valid/ready response channel.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2,
  parameter int ADDR_W  = $clog2(DEPTH)
) (
  input logic        clk,
  input logic        rst,
  dmem_responder_if.slave bus
);

  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $fatal(1, "dmem_responder: LATENCY %0d outside 1..15", LATENCY);
  end

  localparam logic [3:0]  CNT_LOAD = 4'(LATENCY - 1);
  localparam logic [31:0] DEPTH_W  = 32'(DEPTH);

  dmem_state_t r_state;
  logic [3:0]  r_cnt;
  dmem_req_t   r_req;
  logic        r_req_ready;
  logic        r_resp_valid;
  logic        r_resp_err;
  logic [31:0] r_resp_rdata;

  logic        w_in_range;
  logic        w_mem_we;
  logic [31:0] w_mem_rdata;

  // Full 32-bit compare so aliases above DEPTH are reported, not wrapped.
  assign w_in_range = (r_req.addr < DEPTH_W);
  assign w_mem_we   = (r_state == COMMIT) && r_req.we && w_in_range;

  dmem_array #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_array (
    .clk    (clk),
    .rst    (rst),
    .i_we   (w_mem_we),
    .i_addr (r_req.addr[ADDR_W-1:0]),
    .i_wdata(r_req.wdata),
    .i_wstrb(r_req.wstrb),
    .o_rdata(w_mem_rdata)
  );

  // Request FSM. WAIT is always visited, even at LATENCY==1: the counter runs
  // LATENCY-1 down to 0, so resp_valid rises LATENCY+1 cycles after accept and
  // back-to-back requests land LATENCY+3 cycles apart.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_req        <= '0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.req_valid && r_req_ready) begin
            r_req.we    <= bus.req_we;
            r_req.addr  <= bus.req_addr;
            r_req.wdata <= bus.req_wdata;
            r_req.wstrb <= bus.req_wstrb;
            r_cnt       <= CNT_LOAD;
            r_req_ready <= 1'b0;
            r_state     <= WAIT;
          end
        end
        WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state <= COMMIT;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        COMMIT: begin
          r_resp_valid <= 1'b1;
          r_resp_err   <= !w_in_range;
          r_resp_rdata <= (w_in_range && !r_req.we) ? w_mem_rdata : 32'h0;
          r_state      <= RESP;
        end
        RESP: begin
          if (bus.resp_ready) begin
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= '0;
            r_req_ready  <= 1'b1;
            r_state      <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready  = r_req_ready;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_err   = r_resp_err;
  assign bus.resp_rdata = r_resp_rdata;
  assign bus.busy       = (r_state != IDLE) || bus.req_valid;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench: randomized transactions against a word-array reference model.
module tb_dmem_responder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dmem_responder_if a_if ();
  dmem_responder_if b_if ();

  dmem_responder #(.DEPTH(256), .LATENCY(2)) u_dut_a (.clk(clk), .rst(rst), .bus(a_if.slave));
  dmem_responder #(.DEPTH(256), .LATENCY(1)) u_dut_b (.clk(clk), .rst(rst), .bus(b_if.slave));

  int checks = 0;
  int errors = 0;

  logic [31:0] mdl_a [256];
  logic [31:0] mdl_b [256];

  function automatic void model_clear();
    for (int i = 0; i < 256; i++) begin
      mdl_a[i] = '0;
      mdl_b[i] = '0;
    end
  endfunction

  function automatic void model_txn(input bit sel_b, input logic we, input logic [31:0] addr,
                                    input logic [31:0] wdata, input logic [3:0] wstrb,
                                    output logic [31:0] rdata, output logic err);
    logic [31:0] mask;
    logic [31:0] cur;
    rdata = '0;
    err   = 1'b0;
    if (addr >= 32'd256) begin
      err = 1'b1;
      return;
    end
    cur = sel_b ? mdl_b[addr[7:0]] : mdl_a[addr[7:0]];
    if (we) begin
      mask = '0;
      for (int i = 0; i < 4; i++) if (wstrb[i]) mask = mask | (32'hFF << (8 * i));
      cur = (cur & ~mask) | (wdata & mask);
      if (sel_b) mdl_b[addr[7:0]] = cur;
      else       mdl_a[addr[7:0]] = cur;
    end else begin
      rdata = cur;
    end
  endfunction

  // Drive one transaction on DUT A; returns the response and accept-to-resp_valid cycles.
  task automatic run_a(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] wstrb, input int ready_delay,
                       output logic [31:0] rdata, output logic err, output int lat);
    int n;
    a_if.req_we    = we;
    a_if.req_addr  = addr;
    a_if.req_wdata = wdata;
    a_if.req_wstrb = wstrb;
    a_if.req_valid = 1'b1;
    rdata = 'x;
    err   = 1'bx;
    lat   = -1;
    n = 0;
    while (!a_if.req_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!a_if.req_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: req_ready=%0b required 1", a_if.req_ready);
      a_if.req_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    a_if.req_valid = 1'b0;
    n = 0;
    while (!a_if.resp_valid && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!a_if.resp_valid) begin
      checks++; errors++;
      $display("FAIL resp_timeout: resp_valid=%0b required 1", a_if.resp_valid);
      return;
    end
    lat   = n;
    rdata = a_if.resp_rdata;
    err   = a_if.resp_err;
    repeat (ready_delay) begin @(posedge clk); #1; end
    a_if.resp_ready = 1'b1;
    @(posedge clk); #1;
    a_if.resp_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_clear();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    a_if.req_valid = 0; a_if.req_we = 0; a_if.req_addr = 0; a_if.req_wdata = 0;
    a_if.req_wstrb = 0; a_if.resp_ready = 0;
    b_if.req_valid = 0; b_if.req_we = 0; b_if.req_addr = 0; b_if.req_wdata = 0;
    b_if.req_wstrb = 0; b_if.resp_ready = 0;
    do_reset();
    checks++; if (a_if.req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %0b want 1", a_if.req_ready); end
    checks++; if (a_if.resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %0b want 0", a_if.resp_valid); end
    checks++; if (a_if.resp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", a_if.resp_rdata); end
    checks++; if (a_if.resp_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %0b want 0", a_if.resp_err); end
    checks++; if (a_if.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", a_if.busy); end
    checks++; if (b_if.req_ready !== 1'b1) begin errors++; $display("FAIL reset_b_req_ready: got %0b want 1", b_if.req_ready); end
  endtask

  // Drive a list of transactions on A and compare each against the model.
  task automatic test_list(input string name, input logic we_l [$], input logic [31:0] addr_l [$],
                           input logic [31:0] wd_l [$], input logic [3:0] st_l [$]);
    logic [31:0] rd, exp_rd;
    logic er, exp_er;
    int lat;
    for (int i = 0; i < we_l.size(); i++) begin
      run_a(we_l[i], addr_l[i], wd_l[i], st_l[i], 0, rd, er, lat);
      model_txn(0, we_l[i], addr_l[i], wd_l[i], st_l[i], exp_rd, exp_er);
      checks++; if (rd !== exp_rd) begin errors++; $display("FAIL %s_rdata[%0d]: got %h want %h", name, i, rd, exp_rd); end
      checks++; if (er !== exp_er) begin errors++; $display("FAIL %s_err[%0d]: got %0b want %0b", name, i, er, exp_er); end
      checks++; if (lat !== 3) begin errors++; $display("FAIL %s_latency[%0d]: got %0d want 3", name, i, lat); end
    end
  endtask

  task automatic test_basic();
    test_list("basic", '{1'b1, 1'b0}, '{32'd5, 32'd5}, '{32'hDEADBEEF, 32'h0}, '{4'hF, 4'h0});
  endtask

  task automatic test_merge();
    logic [31:0] rd;
    logic er;
    int lat;
    test_list("merge", '{1'b1, 1'b1}, '{32'd7, 32'd7}, '{32'h11223344, 32'hAABBCCDD}, '{4'hF, 4'b0101});
    run_a(1'b0, 32'd7, 32'h0, 4'h0, 1, rd, er, lat);
    checks++; if (rd !== 32'h11BB33DD) begin errors++; $display("FAIL merge_load: got %h want 11bb33dd", rd); end
  endtask

  task automatic test_out_of_range();
    test_list("oob",
      '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0},
      '{32'd300, 32'd300, 32'd44, 32'd5, 32'd5, 32'h8000_0005},
      '{32'h0, 32'hCAFEF00D, 32'h0, 32'h12345678, 32'h0, 32'h0},
      '{4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0});
  endtask

  task automatic test_stall();
    logic [31:0] exp_rd;
    logic exp_er;
    int n;
    a_if.req_we = 1'b0; a_if.req_addr = 32'd5; a_if.req_wdata = 0; a_if.req_wstrb = 0;
    a_if.req_valid = 1'b1;
    model_txn(0, 1'b0, 32'd5, 32'h0, 4'h0, exp_rd, exp_er);
    @(posedge clk); #1;
    a_if.req_valid = 1'b0;
    n = 0;
    while (!a_if.resp_valid && n < 50) begin @(posedge clk); #1; n++; end
    checks++; if (n !== 3) begin errors++; $display("FAIL stall_latency: got %0d want 3", n); end
    // A competing store presented while the response is held must be ignored.
    a_if.req_we = 1'b1; a_if.req_addr = 32'd5; a_if.req_wdata = 32'h0; a_if.req_wstrb = 4'hF;
    a_if.req_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++; if (a_if.resp_valid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d]: got %0b want 1", c, a_if.resp_valid); end
      checks++; if (a_if.resp_rdata !== exp_rd) begin errors++; $display("FAIL stall_rdata[%0d]: got %h want %h", c, a_if.resp_rdata, exp_rd); end
      checks++; if (a_if.resp_err !== exp_er) begin errors++; $display("FAIL stall_err[%0d]: got %0b want %0b", c, a_if.resp_err, exp_er); end
      checks++; if (a_if.req_ready !== 1'b0) begin errors++; $display("FAIL stall_req_ready[%0d]: got %0b want 0", c, a_if.req_ready); end
      checks++; if (a_if.busy !== 1'b1) begin errors++; $display("FAIL stall_busy[%0d]: got %0b want 1", c, a_if.busy); end
      @(posedge clk); #1;
    end
    a_if.req_valid = 1'b0;
    a_if.resp_ready = 1'b1;
    @(posedge clk); #1;
    a_if.resp_ready = 1'b0;
    #1;
    checks++; if (a_if.resp_valid !== 1'b0) begin errors++; $display("FAIL stall_release_valid: got %0b want 0", a_if.resp_valid); end
    checks++; if (a_if.busy !== 1'b0) begin errors++; $display("FAIL stall_release_busy: got %0b want 0", a_if.busy); end
    checks++; if (a_if.req_ready !== 1'b1) begin errors++; $display("FAIL stall_release_ready: got %0b want 1", a_if.req_ready); end
    test_list("stall_after", '{1'b0}, '{32'd5}, '{32'h0}, '{4'h0});
  endtask

  task automatic test_reset_abort();
    int seen;
    a_if.req_we = 1'b1; a_if.req_addr = 32'd9; a_if.req_wdata = 32'h1; a_if.req_wstrb = 4'hF;
    a_if.req_valid = 1'b1;
    @(posedge clk); #1;
    a_if.req_valid = 1'b0;
    rst = 1'b1;
    #2;
    checks++; if (a_if.req_ready !== 1'b1) begin errors++; $display("FAIL abort_req_ready: got %0b want 1", a_if.req_ready); end
    checks++; if (a_if.busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %0b want 0", a_if.busy); end
    @(posedge clk); #1;
    rst = 1'b0;
    model_clear();
    seen = 0;
    repeat (6) begin
      if (a_if.resp_valid) seen++;
      @(posedge clk); #1;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL abort_no_resp: got %0d resp cycles want 0", seen); end
    test_list("abort_load", '{1'b0}, '{32'd9}, '{32'h0}, '{4'h0});
  endtask

  task automatic test_random();
    logic [31:0] rd, exp_rd, addr, wd;
    logic er, exp_er, we;
    logic [3:0] st;
    int lat, dly;
    for (int i = 0; i < 40; i++) begin
      we  = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 7))
        0:       addr = 32'd256 + 32'($urandom_range(0, 15));
        1:       addr = $urandom | 32'h0001_0000;
        default: addr = 32'($urandom_range(0, 15));
      endcase
      wd  = $urandom;
      st  = 4'($urandom_range(0, 15));
      dly = $urandom_range(0, 3);
      run_a(we, addr, wd, st, dly, rd, er, lat);
      model_txn(0, we, addr, wd, st, exp_rd, exp_er);
      checks++; if (rd !== exp_rd) begin errors++; $display("FAIL rand_rdata[%0d]: addr %h got %h want %h", i, addr, rd, exp_rd); end
      checks++; if (er !== exp_er) begin errors++; $display("FAIL rand_err[%0d]: addr %h got %0b want %0b", i, addr, er, exp_er); end
      checks++; if (lat !== 3) begin errors++; $display("FAIL rand_latency[%0d]: got %0d want 3", i, lat); end
    end
  endtask

  task automatic test_back_to_back();
    localparam int N = 8;
    logic        t_we [N];
    logic [31:0] t_addr [N];
    logic [31:0] t_wd [N];
    logic [31:0] exp_d [$];
    logic        exp_e [$];
    int          acc_c [$];
    logic [31:0] rd;
    logic        er, acc;
    int k, cyc, last_acc, n_acc;
    for (int i = 0; i < N; i++) begin
      t_we[i]   = (i % 2 == 0);
      t_addr[i] = 32'($urandom_range(0, 3)) + 32'(i / 2) * 32'd16;
      t_wd[i]   = $urandom;
      if (i % 2 == 1) t_addr[i] = t_addr[i-1];
    end
    k = 0; cyc = 0; last_acc = -1; n_acc = 0;
    b_if.resp_ready = 1'b1;
    while ((k < N || exp_d.size() > 0) && cyc < 200) begin
      if (k < N) begin
        b_if.req_valid = 1'b1;
        b_if.req_we    = t_we[k];
        b_if.req_addr  = t_addr[k];
        b_if.req_wdata = t_wd[k];
        b_if.req_wstrb = 4'hF;
      end else begin
        b_if.req_valid = 1'b0;
      end
      #1;
      if (k < N) begin
        checks++; if (b_if.busy !== 1'b1) begin errors++; $display("FAIL b2b_busy_high: cycle %0d got %0b want 1", cyc, b_if.busy); end
      end
      acc = b_if.req_valid && b_if.req_ready;
      if (b_if.resp_valid && exp_d.size() > 0) begin
        checks++; if (b_if.resp_rdata !== exp_d[0]) begin errors++; $display("FAIL b2b_rdata: got %h want %h", b_if.resp_rdata, exp_d[0]); end
        checks++; if (b_if.resp_err !== exp_e[0]) begin errors++; $display("FAIL b2b_err: got %0b want %0b", b_if.resp_err, exp_e[0]); end
        checks++; if (cyc - acc_c[0] !== 2) begin errors++; $display("FAIL b2b_latency: got %0d want 2", cyc - acc_c[0]); end
        void'(exp_d.pop_front());
        void'(exp_e.pop_front());
        void'(acc_c.pop_front());
      end
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        if (last_acc >= 0) begin
          checks++; if (cyc - last_acc !== 4) begin errors++; $display("FAIL b2b_spacing: got %0d want 4", cyc - last_acc); end
        end
        last_acc = cyc;
        model_txn(1, t_we[k], t_addr[k], t_wd[k], 4'hF, rd, er);
        exp_d.push_back(rd);
        exp_e.push_back(er);
        acc_c.push_back(cyc);
        n_acc++;
        k++;
      end
    end
    b_if.req_valid = 1'b0;
    b_if.resp_ready = 1'b0;
    #1;
    checks++; if (n_acc !== N) begin errors++; $display("FAIL b2b_accepts: got %0d want %0d", n_acc, N); end
    checks++; if (b_if.busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_idle: got %0b want 0", b_if.busy); end
    checks++; if (b_if.req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_idle: got %0b want 1", b_if.req_ready); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_merge();
    test_out_of_range();
    test_stall();
    test_reset_abort();
    test_random();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
